// File: rtl/ex_div_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_div_stage
// Purpose  : Execute stage with a single-cycle logic/arithmetic unit and a
//            32-cycle restoring divider (DIV/DIVU) that stalls the front of
//            the pipeline and posts quotient/remainder to HI/LO.
// Revision : 1.0 - initial release
// ============================================================================
module ex_div_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ex_reg1,
  input  logic [31:0] ex_reg2,
  input  logic [4:0]  ex_waddr,
  input  logic        ex_reg_w_i,
  input  logic [2:0]  alusel_i,
  input  logic [7:0]  aluop_i,
  input  logic        annul_i,
  output logic [31:0] wdata_o,
  output logic [4:0]  waddr_o,
  output logic        reg_w_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        whilo_o,
  output logic        stallreq_o
);

  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_ARITH = 3'b010;

  localparam logic [7:0] OP_AND  = 8'h24;
  localparam logic [7:0] OP_OR   = 8'h25;
  localparam logic [7:0] OP_XOR  = 8'h26;
  localparam logic [7:0] OP_NOR  = 8'h27;
  localparam logic [7:0] OP_ADDU = 8'h21;
  localparam logic [7:0] OP_SUBU = 8'h23;
  localparam logic [7:0] OP_SLT  = 8'h2A;
  localparam logic [7:0] OP_DIV  = 8'h1A;
  localparam logic [7:0] OP_DIVU = 8'h1B;

  localparam logic [4:0] LAST_ITER = 5'd31;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_ZERO = 2'd1,
    DIV_ON   = 2'd2,
    DIV_END  = 2'd3
  } div_state_t;

  div_state_t  state;
  div_state_t  state_nxt;

  // Divider working registers: quo doubles as the dividend shift register.
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] divr;
  logic [4:0]  cnt;
  logic        neg_quo;
  logic        neg_rem;

  // Architecturally visible HI/LO copy held between divides.
  logic [31:0] hi_hold;
  logic [31:0] lo_hold;

  logic        op_is_div;
  logic        op_signed;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [32:0] shifted;
  logic [32:0] diff;
  logic [31:0] quo_final;
  logic [31:0] rem_final;
  logic [31:0] alu_result;
  logic        alu_valid;

  assign op_is_div = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);
  assign op_signed = (aluop_i == OP_DIV);

  // Magnitudes for signed divide; 0x80000000 maps onto itself, which is the
  // correct unsigned magnitude.
  assign mag_a = (op_signed && ex_reg1[31]) ? (~ex_reg1 + 32'd1) : ex_reg1;
  assign mag_b = (op_signed && ex_reg2[31]) ? (~ex_reg2 + 32'd1) : ex_reg2;

  // One restoring step: a clear bit 32 of diff means the trial subtract fit.
  assign shifted = {rem, quo[31]};
  assign diff    = shifted - {1'b0, divr};

  assign quo_final = neg_quo ? (~quo + 32'd1) : quo;
  assign rem_final = neg_rem ? (~rem + 32'd1) : rem;

  // Single-cycle logic and arithmetic result; unlisted sel/op pairs give 0.
  always_comb begin
    alu_result = '0;
    alu_valid  = 1'b0;
    if (alusel_i == SEL_LOGIC) begin
      case (aluop_i)
        OP_AND:  begin alu_result = ex_reg1 & ex_reg2;    alu_valid = 1'b1; end
        OP_OR:   begin alu_result = ex_reg1 | ex_reg2;    alu_valid = 1'b1; end
        OP_XOR:  begin alu_result = ex_reg1 ^ ex_reg2;    alu_valid = 1'b1; end
        OP_NOR:  begin alu_result = ~(ex_reg1 | ex_reg2); alu_valid = 1'b1; end
        default: begin alu_result = '0;                   alu_valid = 1'b0; end
      endcase
    end else if (alusel_i == SEL_ARITH) begin
      case (aluop_i)
        OP_ADDU: begin alu_result = ex_reg1 + ex_reg2; alu_valid = 1'b1; end
        OP_SUBU: begin alu_result = ex_reg1 - ex_reg2; alu_valid = 1'b1; end
        OP_SLT:  begin
          alu_result = {31'd0, ($signed(ex_reg1) < $signed(ex_reg2))};
          alu_valid  = 1'b1;
        end
        default: begin alu_result = '0; alu_valid = 1'b0; end
      endcase
    end
  end

  // Divider state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and output decode; reset and annul override everything.
  always_comb begin
    state_nxt  = state;
    wdata_o    = alu_result;
    waddr_o    = ex_waddr;
    reg_w_o    = alu_valid & ex_reg_w_i;
    hi_o       = hi_hold;
    lo_o       = lo_hold;
    whilo_o    = 1'b0;
    stallreq_o = 1'b0;
    if (rst) begin
      state_nxt = IDLE;
      wdata_o   = '0;
      waddr_o   = '0;
      reg_w_o   = 1'b0;
      hi_o      = '0;
      lo_o      = '0;
    end else if (annul_i) begin
      state_nxt = IDLE;
      reg_w_o   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (op_is_div) begin
            stallreq_o = 1'b1;
            state_nxt  = (ex_reg2 == '0) ? DIV_ZERO : DIV_ON;
          end
        end
        DIV_ZERO: begin
          stallreq_o = 1'b1;
          state_nxt  = DIV_END;
        end
        DIV_ON: begin
          stallreq_o = 1'b1;
          if (cnt == LAST_ITER) begin
            state_nxt = DIV_END;
          end
        end
        DIV_END: begin
          whilo_o   = 1'b1;
          reg_w_o   = 1'b0;
          hi_o      = rem_final;
          lo_o      = quo_final;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Divider datapath: latch operands on start, iterate, then commit HI/LO.
  always_ff @(posedge clk) begin
    if (rst) begin
      quo     <= '0;
      rem     <= '0;
      divr    <= '0;
      cnt     <= '0;
      neg_quo <= 1'b0;
      neg_rem <= 1'b0;
      hi_hold <= '0;
      lo_hold <= '0;
    end else if (!annul_i) begin
      case (state)
        IDLE: begin
          if (op_is_div) begin
            cnt <= '0;
            if (ex_reg2 == '0) begin
              // Divide by zero: fixed quotient, raw dividend as remainder.
              quo     <= 32'hFFFF_FFFF;
              rem     <= ex_reg1;
              divr    <= '0;
              neg_quo <= 1'b0;
              neg_rem <= 1'b0;
            end else begin
              quo     <= mag_a;
              rem     <= '0;
              divr    <= mag_b;
              neg_quo <= op_signed & (ex_reg1[31] ^ ex_reg2[31]);
              neg_rem <= op_signed & ex_reg1[31];
            end
          end
        end
        DIV_ON: begin
          quo <= {quo[30:0], ~diff[32]};
          rem <= diff[32] ? shifted[31:0] : diff[31:0];
          cnt <= cnt + 5'd1;
        end
        DIV_END: begin
          hi_hold <= rem_final;
          lo_hold <= quo_final;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/ex_div_stage.md
EX_DIV_STAGE -- requirements
Module: ex_div_stage

Interface
REQ-001 The block SHALL use the following ports; clk and rst are synchronous and active-high.
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- ex_reg1  in  32  operand A from the ID/EX register (dividend for DIV/DIVU)
- ex_reg2  in  32  operand B from the ID/EX register (divisor for DIV/DIVU)
- ex_waddr  in  5  destination register address
- ex_reg_w_i  in  1  register write enable
- alusel_i  in  3  result class: 000 NOP, 001 LOGIC, 010 ARITH, 011 DIV
- aluop_i  in  8  operation: 00 NOP, 24 AND, 25 OR, 26 XOR, 27 NOR, 21 ADDU, 23 SUBU, 2A SLT, 1A DIV, 1B DIVU (hex)
- annul_i  in  1  cancel the current EX instruction (pipeline flush)
- wdata_o  out  32  result to EX/MEM
- waddr_o  out  5  pass-through of ex_waddr
- reg_w_o  out  1  register write enable to EX/MEM
- hi_o  out  32  remainder of DIV/DIVU
- lo_o  out  32  quotient of DIV/DIVU
- whilo_o  out  1  HI/LO write strobe, 1 cycle
- stallreq_o  out  1  hold PC, IF/ID and ID/EX while high

Function
REQ-002 LOGIC and ARITH ops SHALL complete combinationally in one cycle with stallreq_o=0, whilo_o=0, reg_w_o=ex_reg_w_i.
REQ-003 ADDU/SUBU SHALL wrap modulo 2^32 with no overflow trap; SLT SHALL compare signed and output 32'h1 or 32'h0.
REQ-004 Any unlisted aluop_i or alusel_i SHALL give wdata_o=0, reg_w_o=0, whilo_o=0.
REQ-005 The divider FSM SHALL have states IDLE, DIV_ZERO, DIV_ON, DIV_END.
REQ-006 IDLE: when aluop_i is DIV or DIVU, next state SHALL be DIV_ZERO if ex_reg2==0, else DIV_ON; stallreq_o=1 in that cycle.
REQ-007 DIV_ON SHALL run 32 iterations of restoring shift-subtract (one quotient bit per cycle) with stallreq_o=1, then go to DIV_END.
REQ-008 DIV_ZERO SHALL last 1 cycle with stallreq_o=1, then go to DIV_END with quotient 32'hFFFFFFFF and remainder = dividend.
REQ-009 DIV_END SHALL drive lo_o=quotient, hi_o=remainder, whilo_o=1, stallreq_o=0, reg_w_o=0 for exactly one cycle, then return to IDLE.
REQ-010 DIV SHALL operate on magnitudes, negate the quotient if the operand signs differ, and give the remainder the dividend's sign.
REQ-011 DIV 32'h80000000 / 32'hFFFFFFFF SHALL yield quotient 32'h80000000 and remainder 0.
REQ-012 Operands SHALL be latched on entry to DIV_ON/DIV_ZERO; input changes during a divide SHALL NOT affect its result.
REQ-013 Nonzero divide latency SHALL be 34 cycles from presentation to whilo_o, with 33 stall cycles; divide-by-zero latency SHALL be 3 cycles.
REQ-014 While annul_i=1, stallreq_o, whilo_o and reg_w_o SHALL be 0, and the FSM SHALL go to IDLE on the next edge from any state.
REQ-015 A DIV/DIVU presented in the cycle after DIV_END SHALL start a new divide with no idle gap.
REQ-016 hi_o and lo_o SHALL hold the last divide result until the next DIV_END or reset.

Reset
REQ-017 While rst=1, all outputs SHALL be 0 and the FSM SHALL enter IDLE on the next edge, clearing the iteration counter and latched operands.
REQ-018 Asserting rst mid-divide SHALL abort the divide; no whilo_o pulse SHALL follow.

Verification
REQ-019 ADDU 32'hFFFFFFFF + 32'h2 -> wdata_o=32'h1, reg_w_o=1, stallreq_o=0, same cycle.
REQ-020 SLT 32'hFFFFFFFF vs 32'h1 -> wdata_o=32'h1.
REQ-021 DIVU 100/7 -> stallreq_o high for 33 cycles, then one cycle with whilo_o=1, lo_o=14, hi_o=2.
REQ-022 DIV -7/2 -> lo_o=32'hFFFFFFFD, hi_o=32'hFFFFFFFF; DIV 32'h80000000/-1 -> lo_o=32'h80000000, hi_o=0.
REQ-023 DIVU 5/0 -> stallreq_o high for 2 cycles, then lo_o=32'hFFFFFFFF, hi_o=5, whilo_o=1.
REQ-024 Assert annul_i at DIV_ON iteration 10, then separately rst at iteration 20 -> stallreq_o low the same cycle (annul_i) or by the next edge (rst), no whilo_o, FSM IDLE; the next DIVU 9/3 -> lo_o=3, hi_o=0.
